// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types and message helpers.
// Magnitudes are carried as unsigned (width-1)-bit values; sign is the two's-complement msb.
package ldpc_pkg;

    localparam int unsigned QUAN_WIDTH = 6;

    typedef enum logic {COLLECT, EMIT} cnu_state_t;

    function automatic int unsigned mag_max(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // |v| clamped so that the most negative code maps onto the largest positive magnitude.
    function automatic int unsigned sat_mag(input int v, input int unsigned w);
        int unsigned a;
        a = (v < 0) ? unsigned'(-v) : unsigned'(v);
        return (a > mag_max(w)) ? mag_max(w) : a;
    endfunction

    function automatic logic sign_of(input int v);
        return v < 0;
    endfunction

endpackage

// File: rtl/cnu_min_tracker.sv
// Running min1/min2, min1 position and sign product over one check-node frame.
// Ties leave min1 in place and land in min2.
module cnu_min_tracker
    import ldpc_pkg::*;
#(
    parameter int unsigned MW = 5,
    parameter int unsigned IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          upd,
    input  logic [MW-1:0] mag,
    input  logic          sgn,
    input  logic [IW-1:0] k,
    output logic [MW-1:0] min1,
    output logic [MW-1:0] min2,
    output logic [IW-1:0] idx,
    output logic          sprod
);

    localparam logic [MW-1:0] MAX = MW'(mag_max(MW + 1));

    logic [MW-1:0] min1_q, min1_d;
    logic [MW-1:0] min2_q, min2_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sprod_q, sprod_d;

    always_comb begin
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        sprod_d = sprod_q;
        if (clr) begin
            min1_d  = MAX;
            min2_d  = MAX;
            idx_d   = '0;
            sprod_d = 1'b0;
        end else if (upd) begin
            if (mag < min1_q) begin
                min2_d = min1_q;
                min1_d = mag;
                idx_d  = k;
            end else if (mag < min2_q) begin
                min2_d = mag;
            end
            sprod_d = sprod_q ^ sgn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min1_q  <= MAX;
            min2_q  <= MAX;
            idx_q   <= '0;
            sprod_q <= 1'b0;
        end else begin
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx_q   <= idx_d;
            sprod_q <= sprod_d;
        end
    end

    assign min1  = min1_q;
    assign min2  = min2_q;
    assign idx   = idx_q;
    assign sprod = sprod_q;

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node: collects DEG V2C messages, then emits DEG extrinsic C2V messages.
// Define CNU_OFFSET_EN for offset min-sum (magnitudes reduced by OFFSET, floored at zero).
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int unsigned quan_width = QUAN_WIDTH,
    parameter int unsigned DEG        = 6,
    parameter int unsigned OFFSET     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [quan_width-1:0] v2c,
    input  logic                        v2c_valid,
    output logic                        v2c_ready,
    output logic signed [quan_width-1:0] c2v,
    output logic [$clog2(DEG)-1:0]      c2v_idx,
    output logic                        c2v_valid,
    input  logic                        c2v_ready,
    output logic                        syndrome
);

    localparam int unsigned   MW   = quan_width - 1;
    localparam int unsigned   IW   = $clog2(DEG);
    localparam logic [IW-1:0] LAST = IW'(DEG - 1);
`ifdef CNU_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif
    // A zero offset makes the floor-subtract below an identity.
    localparam logic [MW-1:0] OFF = OFFSET_EN ? MW'(OFFSET) : '0;

    cnu_state_t     state_q, state_d;
    logic [IW-1:0]  k_q, k_d;
    logic [IW-1:0]  j_q, j_d;
    logic [DEG-1:0] sign_q, sign_d;
    logic           syn_q, syn_d;

    logic          sgn, v_hs, c_hs, last_out;
    logic [MW-1:0] mag, min1, min2, m, m_cor;
    logic [IW-1:0] idx;
    logic          sprod, neg;

    assign sgn       = v2c[quan_width-1];
    assign mag       = MW'(sat_mag(int'(v2c), quan_width));
    assign v2c_ready = (state_q == COLLECT) && !rst;
    assign v_hs      = v2c_valid && v2c_ready;
    assign c_hs      = c2v_valid && c2v_ready;
    assign last_out  = c_hs && (j_q == LAST);

    cnu_min_tracker #(
        .MW (MW),
        .IW (IW)
    ) u_tracker (
        .clk   (clk),
        .rst   (rst),
        .clr   (last_out),
        .upd   (v_hs),
        .mag   (mag),
        .sgn   (sgn),
        .k     (k_q),
        .min1  (min1),
        .min2  (min2),
        .idx   (idx),
        .sprod (sprod)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        sign_d  = sign_q;
        syn_d   = syn_q;
        unique case (state_q)
            COLLECT: begin
                if (v_hs) begin
                    sign_d[k_q] = sgn;
                    k_d         = k_q + 1'b1;
                    if (k_q == LAST) begin
                        state_d = EMIT;
                        k_d     = '0;
                        j_d     = '0;
                        syn_d   = sprod ^ sgn;
                    end
                end
            end
            EMIT: begin
                if (c_hs) begin
                    j_d = j_q + 1'b1;
                    if (j_q == LAST) begin
                        state_d = COLLECT;
                        j_d     = '0;
                        sign_d  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            k_q     <= '0;
            j_q     <= '0;
            sign_q  <= '0;
            syn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            sign_q  <= sign_d;
            syn_q   <= syn_d;
        end
    end

    // Outputs decode registered state only; nothing here depends on v2c or c2v_ready.
    always_comb begin
        m         = (j_q == idx) ? min2 : min1;
        m_cor     = (m > OFF) ? m - OFF : '0;
        neg       = sprod ^ sign_q[j_q];
        c2v_valid = (state_q == EMIT);
        c2v_idx   = j_q;
        c2v       = '0;
        if (c2v_valid) begin
            c2v = neg ? -$signed({1'b0, m_cor}) : $signed({1'b0, m_cor});
        end
    end

    assign syndrome = syn_q;

endmodule

// File: tb/tb_cnu_serial.sv
// Scoreboard bench for cnu_serial: a frame-level min-sum model feeds an expectation queue
// that an independent monitor drains on every C2V handshake.
module tb_cnu_serial;

    localparam int QW     = 6;
    localparam int DEG    = 6;
    localparam int OFFSET = 1;
    localparam int MAXM   = 31;

    typedef int frame_t [DEG];
    typedef struct {
        int val;
        int idx;
        int syn;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [QW-1:0] v2c;
    logic                 v2c_valid;
    logic                 v2c_ready;
    logic signed [QW-1:0] c2v;
    logic [2:0]           c2v_idx;
    logic                 c2v_valid;
    logic                 c2v_ready;
    logic                 syndrome;

    cnu_serial #(
        .quan_width (QW),
        .DEG        (DEG),
        .OFFSET     (OFFSET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v2c       (v2c),
        .v2c_valid (v2c_valid),
        .v2c_ready (v2c_ready),
        .c2v       (c2v),
        .c2v_idx   (c2v_idx),
        .c2v_valid (c2v_valid),
        .c2v_ready (c2v_ready),
        .syndrome  (syndrome)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cur_syn  = 0;
    bit   rand_rdy = 1'b0;
    bit   gaps     = 1'b0;
    exp_t exp_q[$];
    int   idx0_cyc[$];

    frame_t basic = '{5, -3, 7, 2, -8, 4};
    frame_t sat   = '{-32, 10, 10, 10, 10, 10};
    frame_t ones  = '{1, 1, 1, 1, 1, 1};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat_abs(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > MAXM) ? MAXM : a;
    endfunction

    // Extrinsic message j: min magnitude and sign parity over all edges except j.
    task automatic push_frame(input frame_t f, output int syn);
        syn = 0;
        for (int i = 0; i < DEG; i++) syn ^= int'(f[i] < 0);
        for (int j = 0; j < DEG; j++) begin
            int   m;
            int   neg;
            exp_t e;
            m   = MAXM;
            neg = 0;
            for (int i = 0; i < DEG; i++) begin
                if (i != j) begin
                    if (sat_abs(f[i]) < m) m = sat_abs(f[i]);
                    neg ^= int'(f[i] < 0);
                end
            end
`ifdef CNU_OFFSET_EN
            m = (m > OFFSET) ? m - OFFSET : 0;
`endif
            e.val = (neg != 0) ? -m : m;
            e.idx = j;
            e.syn = syn;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input frame_t f);
        int syn;
        int n;
        push_frame(f, syn);
        for (int i = 0; i < DEG; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                v2c_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            v2c       = QW'(f[i]);
            v2c_valid = 1'b1;
            @(negedge clk);
            n = 0;
            while (!v2c_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("v2c_ready_timeout", n, 0);
            if (i == DEG - 1) check("syndrome_hold", int'(syndrome), cur_syn);
            @(posedge clk);
            #1;
        end
        v2c_valid = 1'b0;
        cur_syn   = syn;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && c2v_valid && c2v_ready) begin
            check("c2v_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("c2v_idx", int'(c2v_idx), e.idx);
                check("c2v_val", int'(c2v), e.val);
                check("syndrome", int'(syndrome), e.syn);
                if (e.idx == 0) idx0_cyc.push_back(cyc);
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) c2v_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        frame_t f;
        rst       = 1'b1;
        v2c       = '0;
        v2c_valid = 1'b0;
        c2v_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_v2c_ready", int'(v2c_ready), 0);
        check("rst_c2v_valid", int'(c2v_valid), 0);
        check("rst_c2v", int'(c2v), 0);
        check("rst_c2v_idx", int'(c2v_idx), 0);
        check("rst_syndrome", int'(syndrome), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_v2c_ready", int'(v2c_ready), 1);
        @(posedge clk);
        #1;

        send_frame(basic);
        drain();
        send_frame(ones);
        drain();

        // Stall at j = 2 while junk is offered on the input side.
        send_frame(basic);
        c2v_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        c2v_ready = 1'b0;
        v2c       = 6'sd17;
        v2c_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_idx", int'(c2v_idx), exp_q[0].idx);
            check("bp_c2v", int'(c2v), exp_q[0].val);
            check("bp_valid", int'(c2v_valid), 1);
            check("bp_v2c_ready", int'(v2c_ready), 0);
        end
        @(posedge clk);
        #1;
        c2v_ready = 1'b1;
        v2c_valid = 1'b0;
        drain();

        send_frame(sat);
        drain();

        // Partial frame then reset: three inputs are discarded.
        for (int i = 0; i < 3; i++) begin
            v2c       = QW'(sat[i]);
            v2c_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        v2c_valid = 1'b0;
        rst       = 1'b1;
        #2;
        check("midrst_syndrome", int'(syndrome), 0);
        check("midrst_v2c_ready", int'(v2c_ready), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        cur_syn = 0;
        @(posedge clk);
        #1;
        send_frame(basic);
        drain();

        // Back-to-back frames with both sides always ready.
        idx0_cyc.delete();
        send_frame(sat);
        send_frame(basic);
        drain();
        check("b2b_frames", idx0_cyc.size(), 2);
        if (idx0_cyc.size() >= 2) check("b2b_period", idx0_cyc[1] - idx0_cyc[0], 2 * DEG);

        gaps     = 1'b1;
        rand_rdy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DEG; i++) f[i] = int'($urandom_range(0, 63)) - 32;
            if (n == 3) f[2] = 0;
            send_frame(f);
        end
        drain();
        rand_rdy  = 1'b0;
        gaps      = 1'b0;
        c2v_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
